// File: rtl/montre_sysid_ext.sv
// rtl/montre_sysid_ext.sv - system identity, scratch, uptime and tick counter slave
// Read data is registered. A low-word tick read snapshots the high word so that firmware reads of the pair are coherent.
module montre_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID = 32'd1665659394,
  parameter logic [31:0] TIMESTAMP = 32'd0,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter logic [31:0] CLK_HZ    = 32'd50000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [31:0] PRESC_MAX = CLK_HZ - 32'd1;

  logic [31:0] scratch;
  logic [31:0] uptime_s;
  logic [31:0] prescaler;
  logic [63:0] tick;
  logic [31:0] tick_hi_shadow;
  logic [31:0] read_mux;
  logic        write_en;
  logic        uptime_clr;
  logic        presc_wrap;

  // A simultaneous read wins, so the write is dropped.
  assign write_en   = write && !read;
  assign uptime_clr = write_en && (address == 3'd4);
  assign presc_wrap = (prescaler == PRESC_MAX);

  always_comb begin
    read_mux = 32'd0;
    case (address)
      3'd0:    read_mux = SYSTEM_ID;
      3'd1:    read_mux = TIMESTAMP;
      3'd2:    read_mux = VERSION;
      3'd3:    read_mux = scratch;
      3'd4:    read_mux = uptime_s;
      3'd5:    read_mux = tick[31:0];
      3'd6:    read_mux = tick_hi_shadow;
      default: read_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata       <= 32'd0;
      readdatavalid  <= 1'b0;
      tick_hi_shadow <= 32'd0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= read_mux;
        if (address == 3'd5) begin
          tick_hi_shadow <= tick[63:32];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= 32'd0;
    end else if (write_en && (address == 3'd3)) begin
      scratch <= writedata;
    end
  end

  // A clear takes priority over a prescaler wrap in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= 32'd0;
      uptime_s  <= 32'd0;
    end else if (uptime_clr) begin
      prescaler <= 32'd0;
      uptime_s  <= 32'd0;
    end else if (presc_wrap) begin
      prescaler <= 32'd0;
      uptime_s  <= uptime_s + 32'd1;
    end else begin
      prescaler <= prescaler + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick <= 64'd0;
    end else begin
      tick <= tick + 64'd1;
    end
  end

endmodule

// File: tb/tb_montre_sysid_ext.sv
// tb/tb_montre_sysid_ext.sv - directed bench for montre_sysid_ext
module tb_montre_sysid_ext;

  logic        clock;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  int checks;
  int errors;
  int cyc;

  montre_sysid_ext #(
    .CLK_HZ(32'd10)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rising edges since the last reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    address = a;
    read    = 1'b1;
    @(negedge clock);
    read = 1'b0;
    check(tag, {32'd0, readdata}, {32'd0, exp});
    check({tag, "_valid"}, {63'd0, readdatavalid}, 64'd1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    address   = 3'd0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = 32'd0;

    // Reset state and identity words
    repeat (3) @(negedge clock);
    check("rst_rdata", {32'd0, readdata}, 64'd0);
    check("rst_valid", {63'd0, readdatavalid}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_valid", {63'd0, readdatavalid}, 64'd0);
    rd_chk(3'd0, 32'd1665659394, "sysid");
    rd_chk(3'd1, 32'd0, "timestamp");
    rd_chk(3'd2, 32'h0001_0000, "version");
    @(negedge clock);
    check("valid_one_cycle", {63'd0, readdatavalid}, 64'd0);
    check("rdata_hold", {32'd0, readdata}, 64'h0001_0000);
    rd_chk(3'd6, 32'd0, "shadow_rst");

    // Scratch, unused address, RO write ignored
    wr(3'd3, 32'hDEAD_BEEF);
    rd_chk(3'd3, 32'hDEAD_BEEF, "scratch");
    rd_chk(3'd7, 32'd0, "addr7");
    wr(3'd0, 32'h1234_5678);
    rd_chk(3'd0, 32'd1665659394, "sysid_ro");

    // Uptime with CLK_HZ=10
    do_reset();
    wait_until(35);
    rd_chk(3'd4, 32'd3, "uptime_35");
    wait_until(39);
    wr(3'd4, 32'hFFFF_FFFF);
    rd_chk(3'd4, 32'd0, "uptime_clr_on_wrap");
    wait_until(49);
    address = 3'd4;
    read    = 1'b1;
    @(negedge clock);
    check("uptime_before_inc", {32'd0, readdata}, 64'd0);
    @(negedge clock);
    read = 1'b0;
    check("uptime_after_inc", {32'd0, readdata}, 64'd1);
    check("b2b_valid", {63'd0, readdatavalid}, 64'd1);
    @(negedge clock);
    check("b2b_valid_drop", {63'd0, readdatavalid}, 64'd0);

    // Coherent tick pair across a low-word carry
    force dut.tick = 64'h0000_0001_FFFF_FFFF;
    address = 3'd5;
    read    = 1'b1;
    @(negedge clock);
    release dut.tick;
    check("tick_lo", {32'd0, readdata}, 64'hFFFF_FFFF);
    address = 3'd6;
    @(negedge clock);
    read = 1'b0;
    check("tick_hi_shadow", {32'd0, readdata}, 64'h1);

    // Simultaneous read and write
    wr(3'd3, 32'd5);
    address   = 3'd3;
    writedata = 32'd9;
    read      = 1'b1;
    write     = 1'b1;
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
    check("rw_same_cycle", {32'd0, readdata}, 64'd5);
    rd_chk(3'd3, 32'd5, "scratch_kept");

    // Reset during pending valid
    address = 3'd3;
    read    = 1'b1;
    @(posedge clock);
    #1;
    read = 1'b0;
    check("pre_rst_valid", {63'd0, readdatavalid}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_drop_valid", {63'd0, readdatavalid}, 64'd0);
    check("rst_drop_rdata", {32'd0, readdata}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    rd_chk(3'd5, 32'd0, "tick_after_rst");
    rd_chk(3'd3, 32'd0, "scratch_after_rst");
    rd_chk(3'd4, 32'd0, "uptime_after_rst");
    rd_chk(3'd6, 32'd0, "shadow_after_rst");

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
